push_conditioner: RTL and testbench
===================================

Name: push_conditioner

Overview:
- Conditions the four DE1 KEY push-buttons (active-low, bouncing, asynchronous) before they reach the processor's 4-bit push PIO input.
- Per key: synchronisation, debouncing, and a registered active-high level for the PIO.
- Per key: one-cycle press, release and auto-repeat event pulses for the fabric.
- Sits between the board KEY pins and the system's push input, in the clk_clk domain.

Parameters:
- N_KEYS, 4, number of independent key channels.
- DEBOUNCE_CYCLES, 1000000, clocks a changed input must stay stable before it is accepted (20 ms at 50 MHz); legal range ≥2.
- REPEAT_DELAY, 25000000, clocks from accepted press to the first repeat pulse; legal range ≥2.
- REPEAT_PERIOD, 5000000, clocks between subsequent repeat pulses; legal range ≥2.
- REPEAT_EN, 1, 1 enables auto-repeat; 0 means repeat_pulse stays 0.

Ports:
- clk_clk  in  1  system clock.
- reset_reset_n  in  1  asynchronous active-low reset.
- key_n  in  N_KEYS  raw board keys, 0 = pressed, asynchronous.
- push_export  out  N_KEYS  debounced level, 1 = pressed; wired to the push PIO input.
- press_pulse  out  N_KEYS  one-cycle pulse on accepted press.
- release_pulse  out  N_KEYS  one-cycle pulse on accepted release.
- repeat_pulse  out  N_KEYS  one-cycle pulse per auto-repeat while held.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - sync flops reset to 1 (released); debounced state reset to 0.
  - all counters reset to 0; FSM resets to IDLE.
  - all outputs reset to 0.
- Channels are fully independent. Simultaneous activity on several keys produces simultaneous pulses with no arbitration.
- Synchroniser: 2 flops per key. s = ~key_n after two clk_clk edges.
- Debounce, per key: db register plus a counter of width $clog2(DEBOUNCE_CYCLES).
  - s == db: counter clears to 0.
  - s != db and counter < DEBOUNCE_CYCLES-1: counter increments.
  - s != db and counter == DEBOUNCE_CYCLES-1: db toggles and the counter clears.
- Latency: key_n held stable from edge t means push_export changes on edge t+2+DEBOUNCE_CYCLES exactly.
  - A pulse or glitch shorter than DEBOUNCE_CYCLES synchronised cycles produces no change.
  - Any bounce restarts the count.
- push_export = db, driven directly from the register.
- Event FSM per key, states IDLE, DELAY, REPEAT, with an rcnt counter sized for max(REPEAT_DELAY, REPEAT_PERIOD):
  - IDLE, db rises: press_pulse=1 next cycle; rcnt=0; go to DELAY (or HELD-equivalent DELAY with counting inhibited if REPEAT_EN=0).
  - DELAY, rcnt == REPEAT_DELAY-1: repeat_pulse=1; rcnt=0; go to REPEAT. Otherwise rcnt increments.
  - REPEAT, rcnt == REPEAT_PERIOD-1: repeat_pulse=1; rcnt=0. Otherwise rcnt increments.
  - DELAY or REPEAT, db falls: release_pulse=1; rcnt=0; go to IDLE. This has priority over a coinciding repeat (no repeat_pulse that cycle).
- Pulse timing:
  - press_pulse and release_pulse are asserted on the edge after db changes, i.e. one clock after push_export.
  - The first repeat_pulse comes REPEAT_DELAY clocks after press_pulse; later ones every REPEAT_PERIOD clocks.
- Pulse mutual exclusion: press, release and repeat pulses for one key never overlap; each is exactly 1 cycle wide.
- Reset mid-operation: all state is discarded immediately.
  - A key still held at reset release is seen as a fresh press after 2+DEBOUNCE_CYCLES clocks, and press_pulse fires.
- Counters saturate at their terminal compare and never wrap. There is no counter overflow for legal parameters.

Decomposition:
- Package push_conditioner_pkg holds:
  - enum key_state_t {IDLE, DELAY, REPEAT};
  - width helper function cnt_w(n) = (n<=1) ? 1 : $clog2(n).
- Sub-module push_key_channel contains the synchroniser, debounce and FSM for one key. It is instantiated N_KEYS times in a generate loop; the top only does bit slicing.

Test Plan (sim params DEBOUNCE_CYCLES=8, REPEAT_DELAY=20, REPEAT_PERIOD=5):
- Reset, then key_n=4'hF for 50 cycles -> all outputs 0, no pulses.
- key_n[0] falls at edge t and is held -> push_export[0]=1 at t+10, press_pulse[0] single pulse at t+11, other bits stay 0.
- key_n[1] bounces 0/1 every 3 cycles for 40 cycles, then settles 0 at edge t -> no change during bounce; push_export[1]=1 at t+10, exactly one press_pulse.
- key_n[2] held 100 cycles after press_pulse at p -> repeat_pulse[2] at p+20, p+25, p+30 …; releasing gives release_pulse[2] once, and no further repeats.
- key_n[3]=0 held; reset_reset_n asserted mid-DELAY then released at r -> outputs 0 immediately; push_export[3]=1 at r+10, new press_pulse.
- All four keys pressed at the same edge with REPEAT_EN=0 -> 4 concurrent press_pulses; repeat_pulse stays 0; on release, 4 concurrent release_pulses.

Source files
------------

// File: rtl/push_conditioner_pkg.sv
// Shared types and sizing helpers for the push-button conditioner.
package push_conditioner_pkg;

   // Per-key event FSM states.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DELAY  = 2'd1,
      REPEAT = 2'd2
   } key_state_t;

   // Counter width able to hold 0 .. n-1.
   function automatic int unsigned cnt_w(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   // Larger of two unsigned values, used to size the repeat counter.
   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/push_key_channel.sv
// One key: 2-flop synchroniser, stability debounce, press/release/repeat event FSM.
module push_key_channel
   import push_conditioner_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 1000000,
   parameter int unsigned REPEAT_DELAY    = 25000000,
   parameter int unsigned REPEAT_PERIOD   = 5000000,
   parameter bit          REPEAT_EN       = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic key_n,
   output logic push,
   output logic press_pulse,
   output logic release_pulse,
   output logic repeat_pulse
);

   localparam int unsigned DB_W = cnt_w(DEBOUNCE_CYCLES);
   localparam int unsigned RC_W = cnt_w(max_u(REPEAT_DELAY, REPEAT_PERIOD));

   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [RC_W-1:0] RD_LAST = RC_W'(REPEAT_DELAY - 1);
   localparam logic [RC_W-1:0] RP_LAST = RC_W'(REPEAT_PERIOD - 1);

   logic            sync1_q, sync1_d;
   logic            sync2_q, sync2_d;
   logic            db_q, db_d;
   logic [DB_W-1:0] dcnt_q, dcnt_d;
   key_state_t      state_q, state_d;
   logic [RC_W-1:0] rcnt_q, rcnt_d;
   logic            press_q, press_d;
   logic            release_q, release_d;
   logic            repeat_q, repeat_d;
   logic            s_c;

   // Synchronised key level, 1 = pressed.
   assign s_c = ~sync2_q;

   // Synchroniser shift and debounce: accept a new level after it holds for DEBOUNCE_CYCLES samples.
   always_comb begin
      sync1_d = key_n;
      sync2_d = sync1_q;
      db_d    = db_q;
      dcnt_d  = '0;
      if (s_c != db_q) begin
         if (dcnt_q == DB_LAST) begin
            db_d = ~db_q;
         end else begin
            dcnt_d = dcnt_q + DB_W'(1);
         end
      end
   end

   // Event FSM: press on accepted rise, timed repeats while held, release on accepted fall.
   always_comb begin
      state_d   = state_q;
      rcnt_d    = rcnt_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      repeat_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (db_q) begin
               press_d = 1'b1;
               rcnt_d  = '0;
               state_d = DELAY;
            end
         end
         DELAY: begin
            if (!db_q) begin
               release_d = 1'b1;
               rcnt_d    = '0;
               state_d   = IDLE;
            end else if (REPEAT_EN) begin
               if (rcnt_q == RD_LAST) begin
                  repeat_d = 1'b1;
                  rcnt_d   = '0;
                  state_d  = REPEAT;
               end else begin
                  rcnt_d = rcnt_q + RC_W'(1);
               end
            end
         end
         REPEAT: begin
            if (!db_q) begin
               release_d = 1'b1;
               rcnt_d    = '0;
               state_d   = IDLE;
            end else if (rcnt_q == RP_LAST) begin
               repeat_d = 1'b1;
               rcnt_d   = '0;
            end else begin
               rcnt_d = rcnt_q + RC_W'(1);
            end
         end
         default: begin
            rcnt_d  = '0;
            state_d = IDLE;
         end
      endcase
   end

   // State registers; sync flops reset to the released level.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q   <= 1'b1;
         sync2_q   <= 1'b1;
         db_q      <= 1'b0;
         dcnt_q    <= '0;
         state_q   <= IDLE;
         rcnt_q    <= '0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
         repeat_q  <= 1'b0;
      end else begin
         sync1_q   <= sync1_d;
         sync2_q   <= sync2_d;
         db_q      <= db_d;
         dcnt_q    <= dcnt_d;
         state_q   <= state_d;
         rcnt_q    <= rcnt_d;
         press_q   <= press_d;
         release_q <= release_d;
         repeat_q  <= repeat_d;
      end
   end

   assign push          = db_q;
   assign press_pulse   = press_q;
   assign release_pulse = release_q;
   assign repeat_pulse  = repeat_q;

endmodule

// File: rtl/push_conditioner.sv
// Conditions N_KEYS board push-buttons into a debounced PIO level plus event pulses.
module push_conditioner
   import push_conditioner_pkg::*;
#(
   parameter int unsigned N_KEYS          = 4,
   parameter int unsigned DEBOUNCE_CYCLES = 1000000,
   parameter int unsigned REPEAT_DELAY    = 25000000,
   parameter int unsigned REPEAT_PERIOD   = 5000000,
   parameter bit          REPEAT_EN       = 1'b1
) (
   input  logic              clk_clk,
   input  logic              reset_reset_n,
   input  logic [N_KEYS-1:0] key_n,
   output logic [N_KEYS-1:0] push_export,
   output logic [N_KEYS-1:0] press_pulse,
   output logic [N_KEYS-1:0] release_pulse,
   output logic [N_KEYS-1:0] repeat_pulse
);

   // One independent channel per key.
   for (genvar g = 0; g < int'(N_KEYS); g++) begin : g_key
      push_key_channel #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .REPEAT_DELAY    (REPEAT_DELAY),
         .REPEAT_PERIOD   (REPEAT_PERIOD),
         .REPEAT_EN       (REPEAT_EN)
      ) u_ch (
         .clk           (clk_clk),
         .rst_n         (reset_reset_n),
         .key_n         (key_n[g]),
         .push          (push_export[g]),
         .press_pulse   (press_pulse[g]),
         .release_pulse (release_pulse[g]),
         .repeat_pulse  (repeat_pulse[g])
      );
   end

endmodule

// File: tb/tb_push_conditioner.sv
// Scoreboard bench: a window-based reference model predicts every output each cycle.
module tb_push_conditioner;

   localparam int NK = 4;
   localparam int DB = 8;
   localparam int RD = 20;
   localparam int RP = 5;

   typedef struct packed {
      logic [NK-1:0] push;
      logic [NK-1:0] press;
      logic [NK-1:0] rel;
      logic [NK-1:0] rep;
   } out_t;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [NK-1:0] key_n;

   logic [NK-1:0] push_a, press_a, rel_a, rep_a;
   logic [NK-1:0] push_b, press_b, rel_b, rep_b;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   // Reference model state.
   logic [NK-1:0] samp_q[$];
   logic [NK-1:0] syn_q[$];
   logic [NK-1:0] db_m;
   logic [NK-1:0] held_m;
   int            t_press[NK];
   out_t          exp_a[$];
   out_t          exp_b[$];

   always #5 clk = ~clk;

   push_conditioner #(
      .N_KEYS(NK), .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .REPEAT_EN(1'b1)
   ) u_dut (
      .clk_clk(clk), .reset_reset_n(rst_n), .key_n(key_n),
      .push_export(push_a), .press_pulse(press_a), .release_pulse(rel_a), .repeat_pulse(rep_a)
   );

   push_conditioner #(
      .N_KEYS(NK), .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .REPEAT_EN(1'b0)
   ) u_dut_nr (
      .clk_clk(clk), .reset_reset_n(rst_n), .key_n(key_n),
      .push_export(push_b), .press_pulse(press_b), .release_pulse(rel_b), .repeat_pulse(rep_b)
   );

   // Model one clock edge: a level is accepted once the last DB synchronised samples all disagree
   // with it; events follow from press time arithmetic.
   task automatic model_step();
      out_t          ea;
      out_t          eb;
      logic [NK-1:0] s;
      logic          dbp;
      logic          flip;
      int            age;
      ea = '0;
      cyc++;
      if (!rst_n) begin
         samp_q.delete();
         syn_q.delete();
         db_m   = '0;
         held_m = '0;
      end else begin
         s = (samp_q.size() >= 2) ? samp_q[samp_q.size()-2] : '0;
         samp_q.push_back(~key_n);
         if (samp_q.size() > 2) void'(samp_q.pop_front());
         syn_q.push_back(s);
         if (syn_q.size() > DB) void'(syn_q.pop_front());
         for (int k = 0; k < NK; k++) begin
            dbp = db_m[k];
            age = cyc - t_press[k];
            if (!held_m[k] && dbp) begin
               ea.press[k] = 1'b1;
               held_m[k]   = 1'b1;
               t_press[k]  = cyc;
            end else if (held_m[k] && !dbp) begin
               ea.rel[k] = 1'b1;
               held_m[k] = 1'b0;
            end else if (held_m[k] && age >= RD && ((age - RD) % RP) == 0) begin
               ea.rep[k] = 1'b1;
            end
            flip = (syn_q.size() == DB);
            for (int j = 0; j < syn_q.size(); j++) begin
               if (syn_q[j][k] == dbp) flip = 1'b0;
            end
            if (flip) db_m[k] = ~dbp;
         end
         ea.push = db_m;
      end
      eb     = ea;
      eb.rep = '0;
      exp_a.push_back(ea);
      exp_b.push_back(eb);
   endtask

   task automatic chk(input string name, input logic [NK-1:0] act, input logic [NK-1:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s cycle=%0d actual=%h required=%h", name, cyc, act, req);
      end
   endtask

   // Model runs on each active edge, before the bench drives new inputs.
   initial begin
      db_m   = '0;
      held_m = '0;
      for (int k = 0; k < NK; k++) t_press[k] = 0;
      forever begin
         @(posedge clk);
         model_step();
      end
   end

   // Monitor: pop the prediction for the latest edge and compare on the falling edge.
   initial begin
      out_t ea;
      out_t eb;
      forever begin
         @(negedge clk);
         if (exp_a.size() == 0 || exp_b.size() == 0) begin
            chk("sb_underflow", NK'(exp_a.size()), NK'(1));
         end else begin
            ea = exp_a.pop_front();
            eb = exp_b.pop_front();
            if (!rst_n) begin
               ea = '0;
               eb = '0;
            end
            chk("push_a",    push_a,  ea.push);
            chk("press_a",   press_a, ea.press);
            chk("release_a", rel_a,   ea.rel);
            chk("repeat_a",  rep_a,   ea.rep);
            chk("push_b",    push_b,  eb.push);
            chk("press_b",   press_b, eb.press);
            chk("release_b", rel_b,   eb.rel);
            chk("repeat_b",  rep_b,   eb.rep);
         end
      end
   end

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Stimulus: directed scenarios, then randomised bouncing with occasional resets.
   initial begin
      int rate;
      rst_n = 1'b0;
      key_n = '1;
      step(3);
      rst_n = 1'b1;
      step(50);

      // Single press and hold on key 0.
      key_n[0] = 1'b0;
      step(40);
      key_n[0] = 1'b1;
      step(30);

      // Bouncing key 1, then settle pressed and release with bounce.
      for (int i = 0; i < 40; i += 3) begin
         key_n[1] = ~key_n[1];
         step(3);
      end
      key_n[1] = 1'b0;
      step(25);
      for (int i = 0; i < 4; i++) begin
         key_n[1] = ~key_n[1];
         step(2);
      end
      key_n[1] = 1'b1;
      step(30);

      // Long hold on key 2 for auto-repeat.
      key_n[2] = 1'b0;
      step(111);
      key_n[2] = 1'b1;
      step(40);

      // Reset while key 3 is in its delay phase.
      key_n[3] = 1'b0;
      step(15);
      rst_n = 1'b0;
      step(3);
      rst_n = 1'b1;
      step(45);
      key_n[3] = 1'b1;
      step(30);

      // All keys pressed and released together.
      key_n = '0;
      step(60);
      key_n = '1;
      step(30);

      // Randomised activity.
      for (int seg = 0; seg < 12; seg++) begin
         case (seg % 3)
            0:       rate = 1;
            1:       rate = 4;
            default: rate = 40;
         endcase
         for (int c = 0; c < 200; c++) begin
            step();
            for (int k = 0; k < NK; k++) begin
               if ($urandom_range(0, 99) < rate) key_n[k] = ~key_n[k];
            end
            if ($urandom_range(0, 999) == 0) begin
               rst_n = 1'b0;
               step(2);
               rst_n = 1'b1;
            end
         end
      end

      key_n = '1;
      step(40);
      @(negedge clk);
      #1;
      chk("sb_drain", NK'(exp_a.size()), NK'(0));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
